// File: rtl/accu_pkg.sv
// Shared types and width helpers for the round-robin accumulator scheduler.
// Holds the scheduler state enum, default parameter values and the width
// functions that the interface, the core and the top all derive from.
package accu_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned BEATS_DEF   = 4;

    // Sum width: one extra bit per doubling of the beat count, so no overflow
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned beats);
        return data_w + $clog2(beats);
    endfunction

    function automatic int unsigned id_w(input int unsigned num_req);
        return $clog2(num_req);
    endfunction

    localparam int unsigned SUM_W_DEF = DATA_W_DEF + $clog2(BEATS_DEF);
    localparam int unsigned ID_W_DEF  = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } accu_sched_state_e;

endpackage

// File: rtl/accu_rr_sched_if.sv
// Requester and result bus of the accumulator scheduler.
//   req_valid/req_data/req_ready : NUM_REQ streaming byte sources, requester i
//                                  on req_data[i*DATA_W +: DATA_W]
//   res_valid/res_data/res_id/res_abort/res_ready : tagged burst-sum result
// master = sources + result consumer, slave = scheduler.
interface accu_rr_sched_if
    import accu_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BEATS   = BEATS_DEF
);
    localparam int unsigned SUM_W = sum_w(DATA_W, BEATS);
    localparam int unsigned ID_W  = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic [SUM_W-1:0]          res_data;
    logic [ID_W-1:0]           res_id;
    logic                      res_abort;
    logic                      res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_abort
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, res_abort
    );

endinterface

// File: rtl/accu_core.sv
// Shared load/add accumulator with beat counter.
//   clr        : synchronous clear of sum and beat count (new grant / abort)
//   beat_en    : accept data as the next beat of the current burst
//   data       : beat data, zero-extended into the sum
//   sum        : registered partial sum (0 while no beat has been accepted)
//   sum_next_c : sum including the current beat, used to load the result
//   last_beat  : current accepted beat is beat BEATS-1
module accu_core
    import accu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned BEATS  = BEATS_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             beat_en,
    input  logic [DATA_W-1:0]                data,
    output logic [sum_w(DATA_W, BEATS)-1:0]  sum,
    output logic [sum_w(DATA_W, BEATS)-1:0]  sum_next_c,
    output logic                             last_beat
);
    localparam int unsigned SUM_W = sum_w(DATA_W, BEATS);
    localparam int unsigned CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    // Beat 0 loads, later beats add
    assign sum_next_c = ((beat_cnt_q == '0) ? '0 : sum_q) + SUM_W'(data);
    assign last_beat  = beat_en && (beat_cnt_q == CNT_W'(BEATS - 1));
    assign sum        = sum_q;

    // Sum is cleared once the burst completes so an aborted empty burst reads 0
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        sum_d      = sum_q;
        if (clr) begin
            beat_cnt_d = '0;
            sum_d      = '0;
        end else if (beat_en) begin
            if (last_beat) begin
                beat_cnt_d = '0;
                sum_d      = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                sum_d      = sum_next_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            sum_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            sum_q      <= sum_d;
        end
    end

endmodule

// File: rtl/accu_rr_sched.sv
// Round-robin scheduler sharing one BEATS-beat accumulator among NUM_REQ
// streaming requesters. One requester is granted per burst; its beats are
// summed and the total is returned tagged with the requester id.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : accu_rr_sched_if.slave (requester beats + result port)
//   busy       : scheduler is not IDLE
// Optional build macro ACCU_STALL_TIMEOUT_EN: abort a burst after TIMEOUT_CYC
// consecutive stall cycles and return the partial sum with res_abort=1.
// Without it res_abort is tied 0 and the grant is held indefinitely.
module accu_rr_sched
    import accu_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned BEATS       = BEATS_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    accu_rr_sched_if.slave bus,
    output logic           busy
);
    localparam int unsigned SUM_W = sum_w(DATA_W, BEATS);
    localparam int unsigned ID_W  = id_w(NUM_REQ);

    accu_sched_state_e state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              res_valid_q, res_valid_d;
    logic [SUM_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;

`ifdef ACCU_STALL_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               res_abort_q, res_abort_d;
`endif

    logic               pick_found_c;
    logic [ID_W-1:0]    pick_id_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [DATA_W-1:0]  grant_data_c;
    logic               beat_en_c;
    logic               core_clr_c;
    logic [SUM_W-1:0]   core_sum;
    logic [SUM_W-1:0]   core_sum_next_c;
    logic               core_last_beat;

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        pick_found_c = 1'b0;
        pick_id_c    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found_c && bus.req_valid[ID_W'((32'(rr_ptr_q) + i) % NUM_REQ)]) begin
                pick_found_c = 1'b1;
                pick_id_c    = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Only the granted requester is acked, and only while accumulating
    always_comb begin
        req_ready_c = '0;
        if (state_q == ACCUM) begin
            req_ready_c[grant_id_q] = 1'b1;
        end
    end

    assign grant_data_c = bus.req_data[32'(grant_id_q) * DATA_W +: DATA_W];
    assign beat_en_c    = (state_q == ACCUM) && bus.req_valid[grant_id_q];

    accu_core #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (core_clr_c),
        .beat_en    (beat_en_c),
        .data       (grant_data_c),
        .sum        (core_sum),
        .sum_next_c (core_sum_next_c),
        .last_beat  (core_last_beat)
    );

    // Next-state and result-register logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        core_clr_c  = 1'b0;
`ifdef ACCU_STALL_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
        res_abort_d = res_abort_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    grant_id_d = pick_id_c;
                    core_clr_c = 1'b1;
                    state_d    = ACCUM;
`ifdef ACCU_STALL_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            ACCUM: begin
                if (beat_en_c) begin
`ifdef ACCU_STALL_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                    if (core_last_beat) begin
                        res_valid_d = 1'b1;
                        res_data_d  = core_sum_next_c;
                        res_id_d    = grant_id_q;
                        state_d     = RESULT;
`ifdef ACCU_STALL_TIMEOUT_EN
                        res_abort_d = 1'b0;
`endif
                    end
                end
`ifdef ACCU_STALL_TIMEOUT_EN
                else if (stall_cnt_q == STALL_W'(TIMEOUT_CYC - 1)) begin
                    // Stall limit reached this cycle: return what we have
                    res_valid_d = 1'b1;
                    res_data_d  = core_sum;
                    res_id_d    = grant_id_q;
                    res_abort_d = 1'b1;
                    core_clr_c  = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = RESULT;
                end else begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
`endif
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
`ifdef ACCU_STALL_TIMEOUT_EN
            stall_cnt_q <= '0;
            res_abort_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
`ifdef ACCU_STALL_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            res_abort_q <= res_abort_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign busy          = (state_q != IDLE);

`ifdef ACCU_STALL_TIMEOUT_EN
    assign bus.res_abort = res_abort_q;
`else
    assign bus.res_abort = 1'b0;
    // Partial sum and stall limit only matter for the timeout build
    logic unused_c;
    assign unused_c = ^{core_sum, 32'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_accu_rr_sched.sv
// Directed testbench for accu_rr_sched: vector table plus hand-written
// sequences for fairness and stall behaviour.
module tb_accu_rr_sched;

    logic clk;
    logic rst_n;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    accu_rr_sched_if #(.NUM_REQ(4), .DATA_W(8), .BEATS(4)) bus ();

    accu_rr_sched #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .BEATS       (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_rv;
        logic [9:0]  e_sum;
        logic [1:0]  e_id;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int r, input int va, input int d, input int rr,
                                input int er, input int ev, input int es, input int ei,
                                input int eb);
        vec_t m;
        m.rst_n  = 1'(r);
        m.valid  = 4'(va);
        m.data   = 32'(d);
        m.rr     = 1'(rr);
        m.e_rdy  = 4'(er);
        m.e_rv   = 1'(ev);
        m.e_sum  = 10'(es);
        m.e_id   = 2'(ei);
        m.e_busy = 1'(eb);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge
    task automatic apply_vec(input vec_t v, input int idx);
        rst_n         = v.rst_n;
        bus.req_valid = v.valid;
        bus.req_data  = v.data;
        bus.res_ready = v.rr;
        @(negedge clk);
        check($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), 32'(v.e_rdy));
        check($sformatf("v%0d_res_valid", idx), 32'(bus.res_valid), 32'(v.e_rv));
        check($sformatf("v%0d_res_data", idx),  32'(bus.res_data),  32'(v.e_sum));
        check($sformatf("v%0d_res_id", idx),    32'(bus.res_id),    32'(v.e_id));
        check($sformatf("v%0d_res_abort", idx), 32'(bus.res_abort), 32'd0);
        check($sformatf("v%0d_busy", idx),      32'(busy),          32'(v.e_busy));
    endtask

    initial begin
        int exp_order[5];
        int multi;
        int hold_bad;
        logic [3:0] one;

        exp_order = '{0, 1, 2, 3, 0};
        one       = 4'b0001;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        @(negedge clk);

        // Reset state
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0));
        // req0: 10,20,30,40 -> 100
        vecs.push_back(mk(1, 1, 32'h0A, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h0A, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h14, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h1E, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h28, 1,  0, 1, 100, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,       0, 0, 100, 0, 0));
        // req2: 255 x4 -> 1020
        vecs.push_back(mk(1, 4, 32'h00FF0000, 1,  4, 0, 100, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 4, 32'h00FF0000, 1,  4, 0, 100, 0, 1));
        vecs.push_back(mk(1, 4, 32'h00FF0000, 1,  0, 1, 1020, 2, 1));
        vecs.push_back(mk(1, 0, 0, 1,             0, 0, 1020, 2, 0));
        // req1: 1,2, 3-cycle gap (others valid), 3,4, result held 5 cycles
        vecs.push_back(mk(1, 2, 32'h0100, 1,  2, 0, 1020, 2, 1));
        vecs.push_back(mk(1, 2, 32'h0100, 1,  2, 0, 1020, 2, 1));
        vecs.push_back(mk(1, 2, 32'h0200, 1,  2, 0, 1020, 2, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 13, 32'h09000009, 1,  2, 0, 1020, 2, 1));
        vecs.push_back(mk(1, 2, 32'h0300, 1,  2, 0, 1020, 2, 1));
        vecs.push_back(mk(1, 2, 32'h0400, 0,  0, 1, 10, 1, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 15, 32'h01010101, 0,  0, 1, 10, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1,  0, 0, 10, 1, 0));
        // req0: 3 beats, then reset; next burst 5 x4 -> 20
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1, 32'h05, 1,  1, 0, 10, 1, 1));
        vecs.push_back(mk(0, 1, 32'h05, 1,  0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1, 32'h05, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h05, 1,  0, 1, 20, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,       0, 0, 20, 0, 0));

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Fairness: all requesters continuously valid, grant order 0,1,2,3,0
        apply_vec(mk(0, 0, 0, 0,  0, 0, 0, 0, 0), 900);
        rst_n         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = 32'h04030201;
        bus.res_ready = 1'b1;
        multi         = 0;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            check($sformatf("fair%0d_grant", b), 32'(bus.req_ready), 32'(one << exp_order[b]));
            for (int k = 0; k < 4; k++) begin
                if ($countones(bus.req_ready) > 1) multi++;
                @(negedge clk);
            end
            check($sformatf("fair%0d_res_valid", b), 32'(bus.res_valid), 32'd1);
            check($sformatf("fair%0d_res_id", b),    32'(bus.res_id),    32'(exp_order[b]));
            check($sformatf("fair%0d_res_data", b),  32'(bus.res_data),  32'(4 * (exp_order[b] + 1)));
            @(negedge clk);
            check($sformatf("fair%0d_idle", b), 32'(busy), 32'd0);
        end
        check("fair_ready_onehot", 32'(multi), 32'd0);

        // req3 sends 7,8 then stalls (rr_ptr is 1 here)
        bus.res_ready = 1'b0;
        bus.req_valid = 4'h8;
        bus.req_data  = 32'h07000000;
        @(negedge clk);
        check("stall_grant3", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_data = 32'h08000000;
        @(negedge clk);
        bus.req_valid = 4'h0;
`ifdef ACCU_STALL_TIMEOUT_EN
        hold_bad = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c < 16 && (bus.res_valid || bus.req_ready != 4'h8)) hold_bad++;
        end
        check("to_no_early", 32'(hold_bad), 32'd0);
        check("to_res_valid", 32'(bus.res_valid), 32'd1);
        check("to_res_data",  32'(bus.res_data),  32'd15);
        check("to_res_abort", 32'(bus.res_abort), 32'd1);
        check("to_res_id",    32'(bus.res_id),    32'd3);
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = 32'h0;
        @(negedge clk);
        check("to_idle", 32'(busy), 32'd0);
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("to_next_grant0", 32'(bus.req_ready), 32'h1);
        // Zero-beat timeout on req0
        bus.req_valid = 4'h0;
        for (int c = 0; c < 16; c++) @(negedge clk);
        check("to0_res_valid", 32'(bus.res_valid), 32'd1);
        check("to0_res_data",  32'(bus.res_data),  32'd0);
        check("to0_res_abort", 32'(bus.res_abort), 32'd1);
        check("to0_res_id",    32'(bus.res_id),    32'd0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("to0_idle", 32'(busy), 32'd0);
`else
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.res_valid || bus.req_ready != 4'h8 || !busy) hold_bad++;
        end
        check("stall_hold", 32'(hold_bad), 32'd0);
        bus.req_valid = 4'h8;
        bus.req_data  = 32'h09000000;
        @(negedge clk);
        bus.req_data = 32'h0A000000;
        @(negedge clk);
        check("stall_res_valid", 32'(bus.res_valid), 32'd1);
        check("stall_res_data",  32'(bus.res_data),  32'd34);
        check("stall_res_abort", 32'(bus.res_abort), 32'd0);
        check("stall_res_id",    32'(bus.res_id),    32'd3);
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = 32'h0;
        @(negedge clk);
        check("stall_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("stall_next_grant0", 32'(bus.req_ready), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accu_rr_sched.md
Name: accu_rr_sched

Overview:
Round-robin scheduler that shares a single 4-beat accumulator among NUM_REQ streaming requesters.
- Grants one requester per burst and steers its beats into the shared sum.
- Returns the burst total tagged with the requester ID over a valid/ready result port.
- Sits between the per-channel byte sources and the downstream result consumer.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, width of each input beat
BEATS, 4, beats per burst (>=2)
TIMEOUT_CYC, 16, stall limit in cycles; used only with ACCU_STALL_TIMEOUT_EN
Derived localparams: SUM_W = DATA_W + $clog2(BEATS) (10 by default); ID_W = $clog2(NUM_REQ)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_W  per-requester beat data; requester i occupies slice [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester beat accept, one-hot or zero
res_valid  out  1  result valid
res_data  out  SUM_W  burst sum
res_id  out  ID_W  requester that produced res_data
res_abort  out  1  result is a partial sum from a timed-out burst
res_ready  in  1  consumer accepts result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, sum=0.
  - res_valid=0, res_data=0, res_id=0, res_abort=0, busy=0.
  - Any burst in progress is discarded; no result is emitted for it.
- FSM states: IDLE, ACCUM, RESULT.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Register it in grant_id and go to ACCUM.
  - The arbitration cycle consumes no data.
- ACCUM:
  - req_ready[grant_id]=1; all other req_ready bits are 0.
  - A beat is accepted when req_valid[grant_id] & req_ready[grant_id].
  - Beat 0 loads sum=data. Later beats do sum=sum+data, zero-extended to SUM_W; no overflow is possible.
  - beat_cnt increments per accepted beat only. Gaps (valid low) hold the grant, sum and beat_cnt.
  - On acceptance of beat BEATS-1:
    - load res_data=final sum, res_id=grant_id, res_valid=1 at the same edge;
    - clear beat_cnt; go to RESULT.
  - Latency: res_valid rises in the cycle after the last beat is accepted.
- RESULT:
  - req_ready=0. res_valid, res_data and res_id are held stable until res_ready is high.
  - On the handshake: res_valid=0, rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
- Throughput: minimum BEATS+2 cycles per burst when there are no stalls and res_ready is tied high.
- Fairness: a requester that keeps valid asserted continuously is granted within NUM_REQ bursts.
- The grant does not change mid-burst, whatever other requesters do.
- busy = (state != IDLE).
- Requesters other than grant_id that assert valid are never acked and must hold their data.

Optional Feature:
Macro: ACCU_STALL_TIMEOUT_EN
- Defined:
  - In ACCUM, a stall counter counts consecutive cycles with req_valid[grant_id] low. It clears on every accepted beat and on grant.
  - Reaching TIMEOUT_CYC triggers a timeout, including when 0 beats have been accepted.
  - On timeout: emit the partial sum (0 if no beats were accepted) with res_abort=1, go to RESULT, clear beat_cnt.
  - rr_ptr advances normally on the result handshake.
- Not defined: no stall counter is built, res_abort is tied 0, and the grant is held indefinitely.

Decomposition:
- Shared package accu_pkg:
  - state enum accu_sched_state_e {IDLE, ACCUM, RESULT};
  - width helper constants for SUM_W and ID_W;
  - default BEATS and DATA_W constants.
- Sub-module accu_core: load/add accumulator with beat counter.
  - Inputs: beat_en, data.
  - Outputs: sum, last_beat.
  - Instantiated once by accu_rr_sched.
- Arbitration and FSM stay in the top module.

Test Plan:
- Only req0 valid, beats 10,20,30,40 back-to-back, res_ready=1:
  - res_valid high 1 cycle after the beat-40 accept, with res_data=100, res_id=0;
  - busy drops the cycle after the handshake.
- req2 sends 255 x4: res_data=1020, no truncation.
- All four requesters continuously valid, 5 bursts:
  - grant order 0,1,2,3,0;
  - req_ready is never asserted for two requesters at once.
- req1 burst with a 3-cycle valid gap after beat 1, res_ready held low 5 cycles:
  - sum is correct (1+2+3+4=10);
  - res_data/res_id stay stable until the handshake;
  - no new grant is issued until the handshake.
- rst_n low for 1 cycle after beat 2 of a burst:
  - next cycle all outputs are 0 and state is IDLE;
  - the next burst from req0 (5 x4) yields 20, with no stale partial sum.
- With ACCU_STALL_TIMEOUT_EN, TIMEOUT_CYC=16: req3 sends 7,8 then drops valid:
  - after 16 idle cycles, res_data=15, res_abort=1, res_id=3;
  - the next grant goes to req0.
